// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg: shared width, funct codes and FSM states for the HI/LO unit
package muldiv_ctrl_pkg;
  localparam int W_CPU = 32;
  localparam logic [5:0] F_MTHI = 6'h11;
  localparam logic [5:0] F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV = 6'h1a;
  localparam logic [5:0] F_DIVU = 6'h1b;
  typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_FIX} md_state_t;
  function automatic logic is_md_funct(input logic [5:0] f);
    return f inside {F_MTHI, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU};
  endfunction
endpackage

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: issue/result bundle between decode and the HI/LO unit
interface muldiv_ctrl_if;
  import muldiv_ctrl_pkg::*;
  logic op_valid;
  logic [5:0] funct;
  logic [W_CPU-1:0] a;
  logic [W_CPU-1:0] b;
  logic accept;
  logic busy;
  logic done;
  logic [W_CPU-1:0] hi;
  logic [W_CPU-1:0] lo;
  modport master(output op_valid, funct, a, b, input accept, busy, done, hi, lo);
  modport slave(input op_valid, funct, a, b, output accept, busy, done, hi, lo);
endinterface

// File: rtl/muldiv_ctrl_step.sv
// muldiv_step: one shift-add multiply or restoring-divide iteration
module muldiv_step
  import muldiv_ctrl_pkg::*;
#(
  parameter int W = W_CPU
) (
  input  logic           is_div,
  input  logic [2*W-1:0] partial,
  input  logic [W-1:0]   operand,
  output logic [2*W-1:0] next
);
  logic [W:0] sum;
  logic [W:0] rem;
  logic [W-1:0] diff;
  // mul: add multiplicand to upper half when the low bit is set, then shift right;
  // div: shift remainder left and keep the trial subtraction if it does not borrow
  always_comb begin
    sum = {1'b0, partial[2*W-1:W]} + {1'b0, partial[0] ? operand : {W{1'b0}}};
    rem = partial[2*W-1:W-1];
    diff = rem[W-1:0] - operand;
    next = !is_div ? {sum, partial[W-1:1]}
         : (rem >= {1'b0, operand}) ? {diff, partial[W-2:0], 1'b1}
         : {partial[2*W-2:0], 1'b0};
  end
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencer for mult/multu/div/divu/mthi/mtlo driving HI/LO
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
(
  input logic clk,
  input logic rst,
  muldiv_ctrl_if.slave bus
);
  localparam int W = W_CPU;
  localparam int CW = $clog2(W);
  md_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2*W-1:0] acc, step_n, res;
  logic [W-1:0] opnd, hi, lo, abs_a, abs_b, q, r;
  logic is_div, neg_lo, neg_hi, done, start, signed_op, div_op, sa, sb;
  assign bus.accept = bus.op_valid && state == MD_IDLE && is_md_funct(bus.funct);
  assign start = bus.accept && !(bus.funct inside {F_MTHI, F_MTLO});
  assign signed_op = bus.funct == F_MULT || bus.funct == F_DIV;
  assign div_op = bus.funct == F_DIV || bus.funct == F_DIVU;
  assign sa = signed_op && bus.a[W-1];
  assign sb = signed_op && bus.b[W-1];
  assign abs_a = sa ? -bus.a : bus.a;
  assign abs_b = sb ? -bus.b : bus.b;
  assign bus.busy = state != MD_IDLE;
  assign bus.done = done;
  assign bus.hi = hi;
  assign bus.lo = lo;
  muldiv_step #(.W(W)) u_step (.is_div(is_div), .partial(acc), .operand(opnd), .next(step_n));
  // state sequencing: IDLE -> RUN for W steps -> FIX -> IDLE
  always_comb begin
    state_n = state == MD_IDLE ? (start ? MD_RUN : MD_IDLE)
            : state == MD_RUN ? (cnt == CW'(W - 1) ? MD_FIX : MD_RUN)
            : MD_IDLE;
  end
  // sign correction of the unsigned magnitude result
  always_comb begin
    q = neg_lo ? -acc[W-1:0] : acc[W-1:0];
    r = neg_hi ? -acc[2*W-1:W] : acc[2*W-1:W];
    res = is_div ? {r, q} : (neg_lo ? -acc : acc);
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= MD_IDLE;
    else state <= state_n;
  end
  // operand latch, iteration, and HI/LO update
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
      done <= 1'b0;
      cnt <= '0;
      acc <= '0;
      opnd <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
    end else begin
      done <= state == MD_FIX;
      cnt <= state == MD_RUN ? cnt + 1'b1 : '0;
      if (start) begin
        acc <= {{W{1'b0}}, div_op ? abs_a : abs_b};
        opnd <= div_op ? abs_b : abs_a;
        is_div <= div_op;
        neg_lo <= (sa ^ sb) && !(div_op && bus.b == '0);
        neg_hi <= sa;
      end else if (state == MD_RUN) acc <= step_n;
      if (state == MD_FIX) {hi, lo} <= res;
      else if (bus.accept && bus.funct == F_MTHI) hi <= bus.a;
      else if (bus.accept && bus.funct == F_MTLO) lo <= bus.a;
    end
  end
endmodule
